// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter; NUM_REQ must match the arbiter instance.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt;
    logic                 uart_start;
    logic [7:0]           uart_data;
    logic                 uart_tx_active;
    logic                 uart_done_tx;
    logic                 busy;
    logic [IDW-1:0]       grant_id;
    logic                 timeout_err;

    modport master (
        output req, req_data, uart_tx_active, uart_done_tx,
        input  gnt, uart_start, uart_data, busy, grant_id, timeout_err
    );

    modport slave (
        input  req, req_data, uart_tx_active, uart_done_tx,
        output gnt, uart_start, uart_data, busy, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one byte at a time from NUM_REQ requesters into a UART transmitter.
// Optional per-byte watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = IDW + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_ACT,
        WAIT_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   grant_id_q;
    logic [IDW-1:0]   winner;
    logic [7:0]       data_q;
    logic [CW-1:0]    cand;
    logic             found;
    logic             any_req;
    logic             to_hit;
    logic             timeout_err_q;
    logic [NUM_REQ-1:0] gnt_d;
    logic             start_d;
    logic             busy_d;

    assign any_req = |bus.req;

    // Scan from last_grant+1 upward; one conditional subtract keeps the wrap modulo NUM_REQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = CW'(last_grant) + CW'(k + 1);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!found && bus.req[cand[IDW-1:0]]) begin
                winner = cand[IDW-1:0];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (any_req) state_d = LOAD;
            LOAD:      state_d = START;
            START:     state_d = WAIT_ACT;
            WAIT_ACT: begin
                if (bus.uart_done_tx || to_hit) begin
                    state_d = IDLE;
                end else if (bus.uart_tx_active) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: if (bus.uart_done_tx || to_hit) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d   = '0;
        start_d = 1'b0;
        busy_d  = (state_q != IDLE);
        if (state_q == LOAD) begin
            gnt_d[grant_id_q] = 1'b1;
        end
        if (state_q == START) begin
            start_d = 1'b1;
        end
    end

    // Winner's byte and index are captured on the IDLE->LOAD edge so they are already valid while gnt is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_grant <= IDW'(NUM_REQ - 1);
            grant_id_q <= '0;
            data_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                last_grant <= winner;
                grant_id_q <= winner;
                data_q     <= bus.req_data[8*winner +: 8];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic          in_wait;

    assign in_wait = (state_q == WAIT_ACT) || (state_q == WAIT_DONE);
    assign to_hit  = in_wait && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt        <= '0;
            timeout_err_q <= 1'b0;
        end else if (state_q == START) begin
            to_cnt <= '0;
        end else if (in_wait && !bus.uart_done_tx) begin
            if (to_hit) begin
                timeout_err_q <= 1'b1;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end
`else
    assign to_hit        = 1'b0;
    assign timeout_err_q = 1'b0;
`endif

    assign bus.gnt         = gnt_d;
    assign bus.uart_start  = start_d;
    assign bus.uart_data   = data_q;
    assign bus.busy        = busy_d;
    assign bus.grant_id    = grant_id_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: timestamp-based transaction model checked every cycle, plus directed literal checks.
// Define UART_ARB_TIMEOUT_EN for both RTL and bench to exercise the watchdog.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Round-robin pick straight from the rule: first requesting channel after last, wrapping.
    function automatic int rr(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return 0;
    endfunction

    int         cyc    = 0;
    bit         m_busy = 1'b0;
    bit         m_err  = 1'b0;
    int         m_t0   = 0;
    int         m_last = N - 1;
    int         m_gid  = 0;
    logic [7:0] m_data = 8'h00;

    // A transfer accepted at the end of cycle t0 grants in t0+1, starts in t0+2, waits from t0+3 on.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_err  <= 1'b0;
            m_last <= N - 1;
            m_gid  <= 0;
            m_data <= 8'h00;
        end else begin
            cyc <= cyc + 1;
            if (!m_busy) begin
                if (bus.req != '0) begin
                    m_last <= rr(bus.req, m_last);
                    m_gid  <= rr(bus.req, m_last);
                    m_data <= bus.req_data[8*rr(bus.req, m_last) +: 8];
                    m_busy <= 1'b1;
                    m_t0   <= cyc;
                end
            end else if (cyc >= m_t0 + 3) begin
                if (bus.uart_done_tx) begin
                    m_busy <= 1'b0;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cyc - (m_t0 + 2) >= TO) begin
                    m_busy <= 1'b0;
                    m_err  <= 1'b1;
                end
`endif
            end
        end
    end

    int         n_starts = 0;
    int         n_gnts   = 0;
    int         gq[$];
    logic [7:0] dq[$];

    always @(negedge clk) begin
        check("gnt", 32'(bus.gnt), (m_busy && cyc == m_t0 + 1) ? (32'd1 << m_gid) : 32'd0);
        check("uart_start", 32'(bus.uart_start), 32'(m_busy && cyc == m_t0 + 2));
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("uart_data", 32'(bus.uart_data), 32'(m_data));
        check("grant_id", 32'(bus.grant_id), 32'(m_gid));
        check("timeout_err", 32'(bus.timeout_err), 32'(m_err));
        if (bus.gnt != '0) begin
            n_gnts++;
            for (int i = 0; i < N; i++) if (bus.gnt[i]) gq.push_back(i);
        end
        if (bus.uart_start) begin
            n_starts++;
            dq.push_back(bus.uart_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Acts as the transmitter for one byte; optionally drops the served channel's request.
    task automatic serve(input int act_dly, input int done_dly, input bit use_act, input bit drop);
        int k;
        k = 0;
        while (!bus.uart_start && k < 40) begin
            tick(1);
            k++;
        end
        check("start_seen", 32'(bus.uart_start), 32'd1);
        if (!bus.uart_start) return;
        if (drop) bus.req[bus.grant_id] = 1'b0;
        tick(act_dly);
        if (use_act) bus.uart_tx_active = 1'b1;
        tick(done_dly);
        bus.uart_done_tx   = 1'b1;
        bus.uart_tx_active = 1'b0;
        tick(1);
        bus.uart_done_tx = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int eg[5];
        logic [7:0] ed[5];
        int g0, s0;

        bus.req            = '0;
        bus.req_data       = '0;
        bus.uart_tx_active = 1'b0;
        bus.uart_done_tx   = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2);

        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_start", 32'(bus.uart_start), 32'd0);
        check("rst_data", 32'(bus.uart_data), 32'd0);
        check("rst_gid", 32'(bus.grant_id), 32'd0);
        check("rst_err", 32'(bus.timeout_err), 32'd0);

        // Single request: gnt at n+1, start with byte at n+2, busy clears after done.
        bus.req_data = 32'h0000_00A5;
        bus.req      = 4'b0001;
        tick(1);
        check("t1_gnt", 32'(bus.gnt), 32'h1);
        check("t1_busy", 32'(bus.busy), 32'd1);
        bus.req = '0;
        tick(1);
        check("t1_start", 32'(bus.uart_start), 32'd1);
        check("t1_data", 32'(bus.uart_data), 32'hA5);
        bus.req_data = 32'h0000_00FF;
        tick(2);
        bus.uart_tx_active = 1'b1;
        tick(10);
        bus.uart_done_tx   = 1'b1;
        bus.uart_tx_active = 1'b0;
        tick(1);
        bus.uart_done_tx = 1'b0;
        check("t1_idle", 32'(bus.busy), 32'd0);
        check("t1_data_held", 32'(bus.uart_data), 32'hA5);

        // A request pulse that falls before the IDLE sample is never granted.
        tick(1);
        g0 = n_gnts;
        bus.req = 4'b0010;
        #3;
        bus.req = '0;
        tick(5);
        check("drop_ignored", 32'(n_gnts), 32'(g0));

        // Fresh reset, all four requesting continuously: 0,1,2,3 then wrap to 0.
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        gq.delete();
        dq.delete();
        bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req      = 4'hF;
        repeat (5) serve(1, 4, 1'b1, 1'b0);
        bus.req = '0;
        eg = '{0, 1, 2, 3, 0};
        ed = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        check("rr_count", 32'(gq.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("rr_grant", (i < gq.size()) ? 32'(gq[i]) : 32'hDEAD, 32'(eg[i]));
            check("rr_data", (i < dq.size()) ? 32'(dq[i]) : 32'hDEAD, 32'(ed[i]));
        end

        // done without tx_active returns to IDLE; next grant skips forward past idle channels.
        tick(2);
        gq.delete();
        dq.delete();
        bus.req_data = {8'h33, 8'h00, 8'h22, 8'h30};
        bus.req      = 4'b0010;
        serve(0, 3, 1'b0, 1'b1);
        check("nact_idle", 32'(bus.busy), 32'd0);
        bus.req = 4'b1001;
        serve(1, 3, 1'b1, 1'b1);
        bus.req = '0;
        check("nact_g0", (gq.size() > 0) ? 32'(gq[0]) : 32'hDEAD, 32'd1);
        check("nact_g1", (gq.size() > 1) ? 32'(gq[1]) : 32'hDEAD, 32'd3);
        check("nact_d1", (dq.size() > 1) ? 32'(dq[1]) : 32'hDEAD, 32'h33);

        // Reset while in WAIT_DONE clears outputs at once; no replay after release.
        tick(2);
        bus.req_data = 32'h0000_005A;
        bus.req      = 4'b0001;
        tick(1);
        bus.req = '0;
        tick(1);
        tick(1);
        bus.uart_tx_active = 1'b1;
        tick(3);
        check("mid_busy", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        check("mid_rst_start", 32'(bus.uart_start), 32'd0);
        check("mid_rst_data", 32'(bus.uart_data), 32'd0);
        check("mid_rst_gid", 32'(bus.grant_id), 32'd0);
        s0 = n_starts;
        g0 = n_gnts;
        tick(2);
        bus.uart_tx_active = 1'b0;
        rst = 1'b1;
        tick(10);
        check("mid_no_start", 32'(n_starts), 32'(s0));
        check("mid_no_gnt", 32'(n_gnts), 32'(g0));

        // Transmitter never finishes the byte.
        bus.req_data = 32'h0077_0000;
        bus.req      = 4'b0100;
        tick(1);
        bus.req = '0;
        tick(2);
        bus.uart_tx_active = 1'b1;
        tick(TO + 20);
`ifdef UART_ARB_TIMEOUT_EN
        check("to_idle", 32'(bus.busy), 32'd0);
        check("to_err", 32'(bus.timeout_err), 32'd1);
        bus.uart_tx_active = 1'b0;
        bus.req = 4'b0001;
        serve(1, 3, 1'b1, 1'b1);
        tick(2);
        check("to_sticky", 32'(bus.timeout_err), 32'd1);
        rst = 1'b0;
        #1;
        check("to_cleared", 32'(bus.timeout_err), 32'd0);
        tick(1);
        rst = 1'b1;
        tick(2);
`else
        check("wait_busy", 32'(bus.busy), 32'd1);
        check("wait_no_err", 32'(bus.timeout_err), 32'd0);
        bus.uart_done_tx   = 1'b1;
        bus.uart_tx_active = 1'b0;
        tick(1);
        bus.uart_done_tx = 1'b0;
        tick(1);
        check("wait_done_idle", 32'(bus.busy), 32'd0);
`endif

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requester channels (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 65536, SHALL set the per-byte watchdog limit in clk cycles (used only with UART_ARB_TIMEOUT_EN).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  input  NUM_REQ  SHALL carry per-channel transmit requests, held high until granted.
REQ-006 req_data  input  8*NUM_REQ  SHALL carry channel i's byte on bits [8i+7:8i], stable while req[i] is high.
REQ-007 gnt  output  NUM_REQ  SHALL pulse one-hot for one cycle when that channel's byte is latched.
REQ-008 uart_start  output  1  SHALL drive the transmitter start input.
REQ-009 uart_data  output  8  SHALL drive the transmitter byte input.
REQ-010 uart_tx_active  input  1  SHALL be the transmitter busy indication.
REQ-011 uart_done_tx  input  1  SHALL be the transmitter byte-complete pulse.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.
REQ-013 grant_id  output  clog2(NUM_REQ)  SHALL hold the index of the channel currently owning the transmitter.
REQ-014 timeout_err  output  1  SHALL be the sticky watchdog error flag.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, START, WAIT_ACT, WAIT_DONE.
REQ-016 IDLE: if any req bit high, winner SHALL be chosen by round-robin starting at (last_grant+1) mod NUM_REQ, and the FSM SHALL go to LOAD; else stay.
REQ-017 LOAD: uart_data and grant_id SHALL be registered from the winner, gnt[winner] SHALL be high this cycle only, last_grant SHALL update, next state START.
REQ-018 START: uart_start SHALL be high exactly one cycle, next state WAIT_ACT.
REQ-019 WAIT_ACT: uart_tx_active high SHALL move to WAIT_DONE; uart_done_tx high SHALL move directly to IDLE.
REQ-020 WAIT_DONE: uart_done_tx high SHALL move to IDLE.
REQ-021 Latency SHALL be: req sampled in IDLE cycle n -> gnt in cycle n+1 -> uart_start in cycle n+2.
REQ-022 A req bit dropped before the IDLE sample SHALL be ignored; req changes after LOAD SHALL not affect the byte in flight.
REQ-023 uart_data SHALL remain stable from LOAD until return to IDLE.
REQ-024 Requests arriving during a transfer SHALL wait; at most one byte SHALL be in flight.
REQ-025 Only one gnt bit SHALL ever be high; gnt SHALL be zero outside LOAD.
REQ-026 last_grant wrap SHALL be modulo NUM_REQ (channel NUM_REQ-1 followed by channel 0).

Reset
REQ-027 On rst low, asynchronously: state=IDLE, gnt=0, uart_start=0, uart_data=0, grant_id=0, busy=0, timeout_err=0, last_grant=NUM_REQ-1 (channel 0 first priority).
REQ-028 Reset mid-transfer SHALL abandon the byte without a second uart_start after release; no gnt repeat.

Configuration
REQ-029 With UART_ARB_TIMEOUT_EN defined, a counter SHALL clear in START, count in WAIT_ACT/WAIT_DONE, and on reaching TIMEOUT_CYCLES force IDLE and set timeout_err (sticky until reset).
REQ-030 Without UART_ARB_TIMEOUT_EN, no counter SHALL exist, wait states SHALL wait indefinitely, and timeout_err SHALL be tied 0.

Verification
REQ-031 req=0001, data0=0xA5; model tx_active 2 cycles after start, done 10 cycles later -> gnt=0001 at n+1, uart_start pulse at n+2 with uart_data=0xA5, busy low after done.
REQ-032 req=1111 held, bytes 0x10/0x11/0x12/0x13 -> grants in order 0,1,2,3,0 and uart_data sequence 0x10,0x11,0x12,0x13,0x10.
REQ-033 done_tx asserted in WAIT_ACT with tx_active never high -> return to IDLE, next grant proceeds normally.
REQ-034 rst low during WAIT_DONE -> all outputs at reset values immediately; after release with req=0, no uart_start.
REQ-035 UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, done_tx never asserted -> IDLE after 100 wait cycles, timeout_err=1 until rst.
